regfile_dump_ctrl: RTL and testbench

Debug-unit sequencer that reads every entry of the 32×32 MIPS register file through its rs read port and streams each word as four bytes to the UART transmitter. Sits between the debug unit (start/done) and the UART TX, and drives the register-file read address while the pipeline is halted. Serialisation is MSB byte first, register 0 first.

---
 rtl/regfile_dump_ctrl.sv | 99 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
`timescale 1ns/1ps
// Dumps registers 0..N_REGS-1 through the rs read port as MSB-first bytes to the UART TX.
// Latency: start to first o_tx_start is 3 cycles; each byte is held until i_tx_done returns.
module regfile_dump_ctrl #(
    parameter int N_REGS = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rf_addr,
    input  logic [31:0]       i_rf_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_REGS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       r_shift;
    logic [31:0]       w_shift_nxt;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        w_byte_cnt_nxt;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_ADDR;
                end
            end
            // The register file resolves the new address on the falling edge of this cycle.
            S_ADDR:  w_state_nxt = S_LATCH;
            S_LATCH: begin
                w_shift_nxt    = i_rf_data;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = S_SEND;
            end
            S_SEND:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_tx_done) begin
                    if (r_byte_cnt != 2'd3) begin
                        w_shift_nxt    = {r_shift[23:0], 8'h00};
                        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                        w_state_nxt    = S_SEND;
                    end else if (r_addr != LP_LAST) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_tx_start = (r_state == S_SEND);
    assign o_rf_addr  = r_addr;
    assign o_tx_data  = r_shift[31:24];

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
`timescale 1ns/1ps
// Bench for regfile_dump_ctrl: randomized UART latency against a byte-stream model of the register file.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_start, i_tx_done;
    logic [31:0] rf_data;
    logic        o_busy, o_done, o_tx_start;
    logic [4:0]  o_rf_addr;
    logic [7:0]  o_tx_data;

    logic        s_start, s_tx_done;
    logic [31:0] s_rf_data;
    logic        s_busy, s_done, s_tx_start;
    logic [4:0]  s_rf_addr;
    logic [7:0]  s_tx_data;

    logic [31:0] regs [32];

    regfile_dump_ctrl #(.N_REGS(32), .ADDR_W(5)) u_dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_rf_addr(o_rf_addr), .i_rf_data(rf_data), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .i_tx_done(i_tx_done));

    regfile_dump_ctrl #(.N_REGS(6), .ADDR_W(5)) u_dut6 (
        .clk(clk), .i_reset(i_reset), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
        .o_rf_addr(s_rf_addr), .i_rf_data(s_rf_data), .o_tx_data(s_tx_data),
        .o_tx_start(s_tx_start), .i_tx_done(s_tx_done));

    // Register file reads on the falling edge.
    always @(negedge clk) begin
        rf_data   <= regs[o_rf_addr];
        s_rf_data <= regs[s_rf_addr];
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0, cost = 0, bcnt = 0, done_cnt = 0, done_idx = 0, first_tx_idx = 0;
    int w_max = 1, n_cur = 32, resp_w = 1, pend = 0;
    bit spur_en = 1'b0;
    logic [7:0] resp_b;
    logic [7:0] got_log[$];
    logic [7:0] s_bytes[$];
    logic [4:0] max_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Byte k of a dump: register k/4, MSB first.
    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        w = regs[k / 4];
        return w[8 * (3 - (k % 4)) +: 8];
    endfunction

    // UART model and byte-stream compare: answers each request after W cycles, optional spurious done.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (o_tx_start && !i_reset) begin
                resp_w = $urandom_range(1, w_max);
                resp_b = o_tx_data;
                got_log.push_back(resp_b);
                if (bcnt == 0) first_tx_idx = cyc - t0 + 1;
                chk("byte_in_range", (bcnt < 4 * n_cur), 1);
                if (bcnt < 4 * n_cur) begin
                    chk("byte_value", resp_b, exp_byte(bcnt));
                    chk("rf_addr_at_send", o_rf_addr, bcnt / 4);
                end
                chk("no_done_in_send", o_done, 0);
                cost += 1 + resp_w;
                bcnt++;
                i_tx_done = spur_en && ($urandom_range(0, 1) == 1);
                @(negedge clk);
                i_tx_done = 1'b0;
                for (int k = 1; k < resp_w; k++) begin
                    if (o_busy) chk("tx_hold", o_tx_data, resp_b);
                    @(negedge clk);
                end
                if (o_busy) chk("tx_hold", o_tx_data, resp_b);
                i_tx_done = 1'b1;
            end else begin
                i_tx_done = spur_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Completion monitor: done must land exactly when the per-byte costs say it should.
    always @(negedge clk) begin
        if (!i_reset && o_done) begin
            done_cnt++;
            done_idx = cyc - t0 + 1;
            chk("done_cycle", done_idx, 2 * n_cur + cost + 1);
            chk("done_no_tx", o_tx_start, 0);
            chk("done_busy", o_busy, 1);
            chk("bytes_at_done", bcnt, 4 * n_cur);
        end
    end

    task automatic prep();
        bcnt = 0; cost = 0; done_cnt = 0;
        got_log.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("dump_finished", (done_cnt != 0), 1);
        repeat (4) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("idle_after_dump", o_busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_tx_start"}, o_tx_start, 0);
        chk({tag, "_tx_data"}, o_tx_data, 0);
        chk({tag, "_rf_addr"}, o_rf_addr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        i_reset = 1'b1; i_start = 1'b0; s_start = 1'b0; s_tx_done = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_reset_outputs("idle");
        end

        // Fixed W=1 dump of the ramp pattern.
        w_max = 1; spur_en = 1'b0; prep();
        do_start();
        wait_done(5000);
        chk("done_cycle_321", done_idx, 321);
        chk("first_tx_cycle", first_tx_idx, 3);
        chk("n_bytes_ramp", got_log.size(), 128);
        chk("ramp_byte4", got_log[4], 8'h01);
        chk("ramp_byte127", got_log[127], 8'h1F);

        // Random contents, random latency, spurious done pulses outside WAIT.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        w_max = 20; spur_en = 1'b1; prep();
        repeat (5) @(negedge clk);
        do_start();
        wait_done(5000);
        chk("n_bytes_random", got_log.size(), 128);
        spur_en = 1'b0;

        // Repeated start requests during a dump, including in the DONE cycle.
        w_max = 3; prep();
        do_start();
        k = 0;
        do begin
            @(negedge clk);
            i_start = ($urandom_range(0, 2) == 0) || o_done;
            k++;
        end while (!o_done && k < 5000);
        @(negedge clk);
        i_start = 1'b0;
        chk("start_in_done_ignored", o_busy, 0);
        repeat (5) @(negedge clk);
        chk("single_dump_done", done_cnt, 1);
        chk("single_dump_bytes", got_log.size(), 128);

        // Reset while waiting on the first byte of r7, then restart from r0.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        w_max = 8; prep();
        do_start();
        k = 0;
        while (bcnt < 29 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        chk("reached_r7", (bcnt >= 29), 1);
        #3;
        i_reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_reset_idle", o_busy, 0);
        prep();
        do_start();
        wait_done(5000);
        chk("restart_first_byte", got_log[0], regs[0][31:24]);
        chk("restart_n_bytes", got_log.size(), 128);

        // Six-register instance: bytes 20..23 come from r5, address stops at 5.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'hDEAD_BEEF;
        s_bytes.delete(); max_addr = '0; pend = 0; k = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s_tx_done = (pend != 0);
            pend = 0;
            if (s_rf_addr > max_addr) max_addr = s_rf_addr;
            if (s_tx_start) begin
                s_bytes.push_back(s_tx_data);
                pend = 1;
            end
            if (s_done) k++;
        end
        chk("s_n_bytes", s_bytes.size(), 24);
        if (s_bytes.size() == 24) begin
            for (int b = 0; b < 24; b++) chk("s_byte_value", s_bytes[b], exp_byte(b));
            chk("s_byte20", s_bytes[20], 8'hDE);
            chk("s_byte21", s_bytes[21], 8'hAD);
            chk("s_byte22", s_bytes[22], 8'hBE);
            chk("s_byte23", s_bytes[23], 8'hEF);
        end
        chk("s_max_addr", max_addr, 5);
        chk("s_addr_final", s_rf_addr, 5);
        chk("s_done_once", k, 1);
        chk("s_idle", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
